// File: rtl/reg_share_arbiter_if.sv
// Requester-side bus of the shared-register arbiter: requests, write lanes, grant/ack and register view.
// Optional clr line is present only when SYNC_CLEAR_EN is defined.
interface reg_share_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] wdata;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       ack;
    logic [WIDTH-1:0]       q;
    logic                   q_valid;
    logic [2:0]             owner;
    logic                   busy;
`ifdef SYNC_CLEAR_EN
    logic                   clr;

    modport master (output req, wdata, clr, input gnt, ack, q, q_valid, owner, busy);
    modport slave  (input req, wdata, clr, output gnt, ack, q, q_valid, owner, busy);
`else
    modport master (output req, wdata, input gnt, ack, q, q_valid, owner, busy);
    modport slave  (input req, wdata, output gnt, ack, q, q_valid, owner, busy);
`endif
endinterface

// File: rtl/reg_share_arbiter.sv
// Round-robin write arbiter owning one shared WIDTH-bit register; grant -> load+ack -> DWELL hold.
// Latency req->gnt 1 cycle, gnt->q/ack 1 cycle; SYNC_CLEAR_EN adds an IDLE-only synchronous clear.
module reg_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int DWELL = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    reg_share_arbiter_if.slave bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_DWELL = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    win_q, win_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             q_valid_q, q_valid_d;
    logic [2:0]       owner_q, owner_d;
    logic [N_REQ-1:0] ack_q, ack_d;

    logic             pick_vld;
    logic [IW-1:0]    pick_idx;

    // Scan from the highest offset down so the lowest offset from ptr overwrites last and wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req[(int'(ptr_q) + i) % N_REQ]) begin
                pick_vld = 1'b1;
                pick_idx = IW'((int'(ptr_q) + i) % N_REQ);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        cnt_d     = cnt_q;
        q_d       = q_q;
        q_valid_d = q_valid_q;
        owner_d   = owner_q;
        ack_d     = '0;
        case (state_q)
            S_IDLE: begin
`ifdef SYNC_CLEAR_EN
                if (bus.clr) begin
                    q_d       = '0;
                    q_valid_d = 1'b0;
                    owner_d   = '0;
                end else
`endif
                if (pick_vld) begin
                    win_d   = pick_idx;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                // A requester that drops req during its grant cycle aborts without moving the pointer.
                if (bus.req[win_q]) begin
                    q_d          = bus.wdata[int'(win_q)*WIDTH +: WIDTH];
                    q_valid_d    = 1'b1;
                    owner_d      = 3'(win_q);
                    ack_d[win_q] = 1'b1;
                    ptr_d        = (win_q == IW'(N_REQ - 1)) ? '0 : win_q + IW'(1);
                    cnt_d        = CW'(DWELL - 1);
                    state_d      = S_DWELL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DWELL: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            cnt_q     <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            owner_q   <= '0;
            ack_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            cnt_q     <= cnt_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            owner_q   <= owner_d;
            ack_q     <= ack_d;
        end
    end

    assign bus.gnt     = (state_q == S_GRANT) ? (N_REQ'(1) << win_q) : '0;
    assign bus.ack     = ack_q;
    assign bus.q       = q_q;
    assign bus.q_valid = q_valid_q;
    assign bus.owner   = owner_q;
    assign bus.busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Bench for reg_share_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_reg_share_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int DW = 2;

    logic clk = 1'b0;
    logic rst_n_r = 1'b0;
    always #5 clk = ~clk;

    reg_share_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus();

    reg_share_arbiter #(.N_REQ(N), .WIDTH(W), .DWELL(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n_r),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: remaining busy cycles, current winner, pointer and register view.
    int           m_rem   = 0;
    int           m_win   = 0;
    int           m_ptr   = 0;
    logic [W-1:0] m_q     = '0;
    logic         m_qv    = 1'b0;
    int           m_owner = 0;
    logic [N-1:0] m_ack   = '0;

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int off = 0; off < N; off++) begin
            if (r[(p + off) % N]) return (p + off) % N;
        end
        return -1;
    endfunction

    function automatic int oh_idx(input logic [N-1:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [N-1:0] m_gnt();
        logic [N-1:0] v;
        v = '0;
        if (m_rem == DW + 1) v[m_win] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_rem = 0; m_win = 0; m_ptr = 0; m_q = '0; m_qv = 1'b0; m_owner = 0; m_ack = '0;
    endtask

    task automatic model_edge();
        m_ack = '0;
        if (!rst_n_r) begin
            model_reset();
        end else if (m_rem == 0) begin
`ifdef SYNC_CLEAR_EN
            if (bus.clr) begin
                m_q = '0; m_qv = 1'b0; m_owner = 0;
            end else
`endif
            if (bus.req != '0) begin
                m_win = rr_pick(bus.req, m_ptr);
                m_rem = DW + 1;
            end
        end else if (m_rem == DW + 1) begin
            if (bus.req[m_win]) begin
                m_q          = bus.wdata[m_win*W +: W];
                m_qv         = 1'b1;
                m_owner      = m_win;
                m_ack[m_win] = 1'b1;
                m_ptr        = (m_win + 1) % N;
                m_rem        = DW;
            end else begin
                m_rem = 0;
            end
        end else begin
            m_rem--;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 40 && m_rem != 0; c++) tick();
    endtask

    task automatic test_reset();
        bus.req = '0;
        bus.wdata = '0;
`ifdef SYNC_CLEAR_EN
        bus.clr = 1'b0;
`endif
        rst_n_r = 1'b0;
        model_reset();
        repeat (3) tick();
        checks++;
        if ({bus.gnt, bus.ack, bus.q, bus.q_valid, bus.owner, bus.busy} !== '0)
            begin failures++; $display("FAIL reset_state got gnt=%b ack=%b q=%h qv=%b own=%0d busy=%b want all 0",
                bus.gnt, bus.ack, bus.q, bus.q_valid, bus.owner, bus.busy); end
        rst_n_r = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if ({bus.gnt, bus.ack, bus.q, bus.q_valid, bus.busy} !== '0)
                begin failures++; $display("FAIL idle_quiet cyc=%0d got gnt=%b ack=%b q=%h qv=%b busy=%b want all 0",
                    c, bus.gnt, bus.ack, bus.q, bus.q_valid, bus.busy); end
        end
    endtask

    task automatic test_round_robin();
        int gs[4]; logic [W-1:0] qs[4]; int ld[4]; int ng; int nl;
        ng = 0; nl = 0;
        bus.wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.req   = 4'b1111;
        for (int c = 0; c < 60 && nl < 4; c++) begin
            tick();
            if (bus.gnt != '0 && ng < 4) begin gs[ng] = oh_idx(bus.gnt); ng++; end
            if (bus.ack != '0) begin
                qs[nl] = bus.q; ld[nl] = c; nl++;
                bus.req = bus.req & ~bus.ack;
            end
        end
        bus.req = '0;
        checks++;
        if (nl != 4 || ng != 4) begin failures++; $display("FAIL rr_timeout got loads=%0d grants=%0d want 4", nl, ng); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (gs[i] != i || qs[i] !== W'(8'h11 * (i + 1)))
                    begin failures++; $display("FAIL rr_order slot=%0d got gnt=%0d q=%h want gnt=%0d q=%h",
                        i, gs[i], qs[i], i, W'(8'h11 * (i + 1))); end
                if (i > 0) begin
                    checks++;
                    if (ld[i] - ld[i-1] != DW + 2)
                        begin failures++; $display("FAIL rr_spacing slot=%0d got %0d want %0d", i, ld[i] - ld[i-1], DW + 2); end
                end
            end
        end
        wait_idle();
    endtask

    task automatic test_wrap();
        int gs[2]; logic [W-1:0] qs[2]; int ng;
        ng = 0;
        bus.wdata = {8'hC3, 8'h00, 8'h00, 8'h5A};
        bus.req   = 4'b1001;
        for (int c = 0; c < 40 && ng < 2; c++) begin
            tick();
            if (bus.ack != '0 && ng < 2) begin
                gs[ng] = oh_idx(bus.ack); qs[ng] = bus.q; ng++;
                bus.req = bus.req & ~bus.ack;
            end
        end
        bus.req = '0;
        checks++;
        if (ng != 2 || gs[0] != 0 || gs[1] != 3 || qs[0] !== 8'h5A || qs[1] !== 8'hC3)
            begin failures++; $display("FAIL wrap_order got n=%0d first=%0d/%h second=%0d/%h want 0/5a then 3/c3",
                ng, gs[0], qs[0], gs[1], qs[1]); end
        wait_idle();
    endtask

    task automatic test_single_write();
        int busy_cyc; int ack_cyc;
        bus.wdata = {W'($urandom), 8'hA5, W'($urandom), W'($urandom)};
        bus.req   = 4'b0100;
        tick();
        checks++;
        if (bus.gnt !== 4'b0100 || bus.ack !== 4'b0000 || bus.busy !== 1'b1)
            begin failures++; $display("FAIL single_grant got gnt=%b ack=%b busy=%b want 0100 0000 1", bus.gnt, bus.ack, bus.busy); end
        bus.wdata[7:0] = W'($urandom);
        tick();
        checks++;
        if (bus.q !== 8'hA5 || bus.ack !== 4'b0100 || bus.owner !== 3'd2 || bus.q_valid !== 1'b1 || bus.gnt !== 4'b0000)
            begin failures++; $display("FAIL single_load got q=%h ack=%b own=%0d qv=%b gnt=%b want a5 0100 2 1 0000",
                bus.q, bus.ack, bus.owner, bus.q_valid, bus.gnt); end
        bus.req = '0;
        busy_cyc = 2; ack_cyc = 1;
        for (int c = 0; c < 20 && bus.busy; c++) begin
            tick();
            if (bus.busy) busy_cyc++;
            if (bus.ack != '0) ack_cyc++;
        end
        checks++;
        if (busy_cyc != 1 + DW || ack_cyc != 1)
            begin failures++; $display("FAIL single_busy got busy=%0d ack=%0d want busy=%0d ack=1", busy_cyc, ack_cyc, 1 + DW); end
        wait_idle();
    endtask

    task automatic test_abort();
        bus.wdata = {8'h00, 8'h00, 8'h3C, 8'h00};
        bus.req   = 4'b0010;
        tick();
        checks++;
        if (bus.gnt !== 4'b0010) begin failures++; $display("FAIL abort_grant got %b want 0010", bus.gnt); end
        bus.req = '0;
        tick();
        checks++;
        if (bus.ack !== 4'b0000 || bus.q !== 8'hA5 || bus.busy !== 1'b0)
            begin failures++; $display("FAIL abort_idle got ack=%b q=%h busy=%b want 0000 a5 0", bus.ack, bus.q, bus.busy); end
        bus.req = 4'b0010;
        tick();
        checks++;
        if (bus.gnt !== 4'b0010) begin failures++; $display("FAIL abort_regrant got %b want 0010", bus.gnt); end
        tick();
        checks++;
        if (bus.ack !== 4'b0010 || bus.q !== 8'h3C || bus.owner !== 3'd1)
            begin failures++; $display("FAIL abort_reload got ack=%b q=%h own=%0d want 0010 3c 1", bus.ack, bus.q, bus.owner); end
        bus.req = '0;
        wait_idle();
    endtask

    task automatic test_async_reset();
        bus.wdata = {8'h00, 8'h00, 8'h00, 8'h77};
        bus.req   = 4'b0001;
        tick();
        tick();
        bus.req = '0;
        checks++;
        if (bus.q !== 8'h77 || bus.busy !== 1'b1)
            begin failures++; $display("FAIL arst_setup got q=%h busy=%b want 77 1", bus.q, bus.busy); end
        #2;
        rst_n_r = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.q !== '0 || bus.busy !== 1'b0 || bus.ack !== '0 || bus.q_valid !== 1'b0 || bus.gnt !== '0)
            begin failures++; $display("FAIL arst_immediate got q=%h busy=%b ack=%b qv=%b gnt=%b want all 0",
                bus.q, bus.busy, bus.ack, bus.q_valid, bus.gnt); end
        @(negedge clk);
        tick();
        rst_n_r = 1'b1;
        tick();
        checks++;
        if (bus.q !== '0 || bus.busy !== 1'b0 || bus.ack !== '0)
            begin failures++; $display("FAIL arst_after got q=%h busy=%b ack=%b want 0 0 0", bus.q, bus.busy, bus.ack); end
    endtask

`ifdef SYNC_CLEAR_EN
    task automatic test_clear();
        bus.wdata = {8'h00, 8'h00, 8'h99, 8'h00};
        bus.req   = 4'b0010;
        tick();
        tick();
        bus.req = '0;
        wait_idle();
        bus.clr = 1'b1;
        bus.req = 4'b0001;
        tick();
        bus.clr = 1'b0;
        checks++;
        if (bus.q !== '0 || bus.q_valid !== 1'b0 || bus.gnt !== '0 || bus.owner !== '0)
            begin failures++; $display("FAIL clear_idle got q=%h qv=%b gnt=%b own=%0d want 0 0 0000 0",
                bus.q, bus.q_valid, bus.gnt, bus.owner); end
        tick();
        checks++;
        if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL clear_then_grant got %b want 0001", bus.gnt); end
        tick();
        bus.req = '0;
        wait_idle();
    endtask
`endif

    task automatic test_random();
        int wait_c[N];
        int max_wait;
        max_wait = 0;
        for (int i = 0; i < N; i++) wait_c[i] = 0;
        bus.req = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) bus.wdata[i*W +: W] = W'($urandom);
            tick();
            checks++;
            if (bus.gnt !== m_gnt() || bus.ack !== m_ack || bus.busy !== (m_rem != 0))
                begin failures++; $display("FAIL rand_ctrl cyc=%0d got gnt=%b ack=%b busy=%b want gnt=%b ack=%b busy=%b",
                    c, bus.gnt, bus.ack, bus.busy, m_gnt(), m_ack, (m_rem != 0)); end
            checks++;
            if (bus.q !== m_q || bus.q_valid !== m_qv || bus.owner !== 3'(m_owner))
                begin failures++; $display("FAIL rand_reg cyc=%0d got q=%h qv=%b own=%0d want q=%h qv=%b own=%0d",
                    c, bus.q, bus.q_valid, bus.owner, m_q, m_qv, m_owner); end
            bus.req = bus.req & ~m_ack;
            if (m_gnt() != '0 && $urandom_range(0, 7) == 0) bus.req = bus.req & ~m_gnt();
            for (int i = 0; i < N; i++) begin
                if (bus.req[i]) wait_c[i]++;
                else wait_c[i] = 0;
                if (wait_c[i] > max_wait) max_wait = wait_c[i];
                if (!bus.req[i] && !m_ack[i] && $urandom_range(0, 3) == 0) bus.req[i] = 1'b1;
            end
        end
        bus.req = '0;
        checks++;
        if (max_wait > N * (DW + 2) + 2)
            begin failures++; $display("FAIL rand_starve got max_wait=%0d want <=%0d", max_wait, N * (DW + 2) + 2); end
        wait_idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_round_robin();
        test_wrap();
        test_single_write();
        test_abort();
        test_async_reset();
`ifdef SYNC_CLEAR_EN
        test_clear();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_share_arbiter.md
Name: reg_share_arbiter

Overview:
- Shares one WIDTH-bit D-flip-flop storage register between N_REQ requesters.
- Round-robin arbitration, one write at a time, with a minimum dwell after each write so downstream logic sees a stable value.
- Sits between the requesting datapath blocks and the shared register bank. The register itself is held inside this block.
- Write sequence: request, one-cycle grant, load, acknowledge.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, width of the shared register and of each write-data lane.
- DWELL, 2, cycles (1..15) the register is held after a load before the next grant.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester write request, level; held until ack.
- wdata  in  N_REQ*WIDTH  write lanes; lane i is wdata[i*WIDTH +: WIDTH].
- gnt  out  N_REQ  one-hot grant, asserted during the GRANT cycle only.
- ack  out  N_REQ  one-hot, one-cycle pulse confirming the load.
- q  out  WIDTH  shared register contents.
- q_valid  out  1  high once q holds a loaded value.
- owner  out  3  index of the requester that last loaded q.
- busy  out  1  high in GRANT and DWELL.

Behaviour:
- Reset (rst_n low, asynchronous), regardless of state:
  - state=IDLE, rr pointer=0, dwell counter=0.
  - gnt=0, ack=0, q=0, q_valid=0, owner=0, busy=0.
- Release of rst_n is synchronised by design: the first transition happens at the first rising edge after rst_n is high.
- FSM states: IDLE, GRANT, DWELL.
- IDLE:
  - If req != 0, pick the first set bit searching from ptr upward with wrap (ptr, ptr+1, ..., N_REQ-1, 0, ...).
  - Latch the winner index and go to GRANT. If req == 0, stay.
- GRANT (exactly 1 cycle):
  - gnt[winner]=1, busy=1.
  - At the closing edge, if req[winner] is still 1:
    - q <= lane[winner], q_valid <= 1, owner <= winner.
    - ack[winner]=1 during the next cycle.
    - ptr <= (winner+1) mod N_REQ; counter <= DWELL-1; go to DWELL.
  - At the closing edge, if req[winner] dropped (abort): no load, no ack, ptr unchanged, go to IDLE.
- DWELL:
  - busy=1, q stable, gnt=0.
  - Counter decrements each cycle; at 0, go to IDLE.
  - The ack pulse occupies the first DWELL cycle.
- Latency: req rises before edge k → gnt during cycle k+1 → q updated and ack during cycle k+2. Minimum spacing between loads is DWELL+2 cycles.
- Requesters deassert req in the cycle ack is seen. A req still high after the dwell is treated as a new request.
- Simultaneous requests: only one is granted per arbitration. The rotating pointer gives each active requester a grant within N_REQ arbitration rounds; no starvation.
- wdata on non-granted lanes is ignored. Lane data is sampled only at the GRANT closing edge.
- Reset asserted mid-GRANT or mid-DWELL discards the transaction: no ack is issued, and q returns to 0.
- ptr wraps N_REQ-1 → 0.

Optional Feature:
- Macro: SYNC_CLEAR_EN.
- Defined:
  - Adds input port clr (1 bit).
  - clr high at an edge while in IDLE: q <= 0, q_valid <= 0, owner <= 0, and no grant is issued that edge (clear wins over arbitration).
  - clr is ignored in GRANT and DWELL.
- Undefined: no clr port; q is cleared only by rst_n.

Test Plan:
- Reset then idle: rst_n low 3 cycles, req=0 for 10 cycles → gnt=0, ack=0, q=0x00, q_valid=0, busy=0 throughout.
- Single write: req=4'b0100, lane2=0xA5 → gnt=4'b0100 one cycle later, then q=0xA5, ack=4'b0100 one cycle, owner=2, q_valid=1; busy high for 1+DWELL cycles.
- Round-robin fairness: req=4'b1111 held, each requester drops req on its ack, lanes=0x11,0x22,0x33,0x44 → grant order 0,1,2,3; q sequence 0x11,0x22,0x33,0x44; loads spaced DWELL+2=4 cycles apart.
- Wrap and pointer: after a load by requester 3, assert req=4'b1001 → requester 0 granted before requester 3.
- Abort: req=4'b0010, drop req[1] during the GRANT cycle → no ack, q unchanged, return to IDLE; reassert → requester 1 granted.
- Async reset mid-DWELL: rst_n pulled low between edges during DWELL → q=0, busy=0, ack=0 immediately without a clock edge. With SYNC_CLEAR_EN, clr=1 and req=4'b0001 in IDLE → q=0, q_valid=0, no gnt that cycle; gnt=4'b0001 the following cycle.
